// File: rtl/load_param_packer.sv
// rtl/load_param_packer.sv - packs BUS_W-bit bus words into DSIZE-bit entries for the parameter FIFO
// Collects WPE words per entry, pushes on winc when the FIFO is not full, flags done after NUM_ENTRIES.
module load_param_packer #(
   parameter int  DSIZE       = 64,
   parameter int  BUS_W       = 32,
   parameter int  NUM_ENTRIES = 256,
   localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [BUS_W-1:0] s_data,
   output logic             winc,
   output logic [DSIZE-1:0] wdata,
   input  logic             wfull,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] entry_count
);

   localparam int WPE    = (DSIZE + BUS_W - 1) / BUS_W;
   localparam int IDX_W  = (WPE > 1) ? $clog2(WPE) : 1;
   localparam int PACK_W = WPE * BUS_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPE - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUSH    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic [CNT_W-1:0]   entry_count_q, entry_count_d;
   logic [DSIZE-1:0]   pack_q, pack_d;
   logic [PACK_W-1:0]  pack_ext;

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state_q       <= IDLE;
         word_idx_q    <= '0;
         entry_count_q <= '0;
         pack_q        <= '0;
      end else begin
         state_q       <= state_d;
         word_idx_q    <= word_idx_d;
         entry_count_q <= entry_count_d;
         pack_q        <= pack_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      word_idx_d    = word_idx_q;
      entry_count_d = entry_count_q;
      pack_d        = pack_q;
      s_ready       = 1'b0;
      winc          = 1'b0;
      // Widened view so the last word may overhang DSIZE; the overhang is dropped on write-back.
      pack_ext              = '0;
      pack_ext[DSIZE-1:0]   = pack_q;

      case (state_q)
         IDLE: begin
         end
         COLLECT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               for (int w = 0; w < WPE; w++) begin
                  if (word_idx_q == IDX_W'(w)) begin
                     pack_ext[w*BUS_W +: BUS_W] = s_data;
                  end
               end
               pack_d = pack_ext[DSIZE-1:0];
               if (word_idx_q == LAST_IDX) begin
                  word_idx_d = '0;
                  state_d    = PUSH;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end
         end
         PUSH: begin
            winc = ~wfull;
            if (!wfull) begin
               entry_count_d = entry_count_q + 1'b1;
               state_d       = (entry_count_d == FULL_CNT) ? DONE : COLLECT;
            end
         end
         DONE: begin
         end
         default: state_d = IDLE;
      endcase

      // A restart wins over everything except reset; an in-flight push still reaches the FIFO.
      if (start) begin
         state_d       = COLLECT;
         word_idx_d    = '0;
         entry_count_d = '0;
      end
   end

   assign wdata       = pack_q;
   assign busy        = (state_q == COLLECT) || (state_q == PUSH);
   assign done        = (state_q == DONE);
   assign entry_count = entry_count_q;

endmodule
